// File: rtl/ymux4_rr_arbiter_if.sv
// ymux4_rr_arbiter_if
//   Bundles the four producer ports, the consumer handshake and the arbiter
//   outputs. The arbiter connects through the slave modport. The environment
//   that holds the producers and the consumer connects through the master modport.
//   Parameter W : word width
//   req[3:0]    : per-requester "word offered"
//   d0..d3      : requester words
//   lock[3:0]   : grant-hold requests (only used when ARB_LOCK_EN is defined)
//   gnt[3:0]    : one-hot grant, pulsed while the word is being sampled
//   sel[1:0]    : registered mux select
//   out_valid / out_data / out_ready : downstream valid/ready handshake
interface ymux4_rr_arbiter_if #(parameter int W = 8);
  logic [3:0]   req;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   lock;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport slave (
    input  req, d0, d1, d2, d3, lock, out_ready,
    output gnt, sel, out_valid, out_data
  );

  modport master (
    output req, d0, d1, d2, d3, lock, out_ready,
    input  gnt, sel, out_valid, out_data
  );
endinterface

// File: rtl/ymux4_rr_arbiter.sv
// ymux4_rr_arbiter
//   Round-robin sharing of one yMux4to1 #(W) datapath among 4 requesters.
//   The winner's index is registered onto the mux select. One cycle later the
//   mux output is captured into out_data and offered downstream on a
//   valid/ready handshake. If a request is pending when a word is accepted,
//   arbitration happens on that same edge, so there is no idle bubble.
//   Ports:
//     clk      : rising-edge clock
//     reset_n  : synchronous active-low reset
//     bus      : ymux4_rr_arbiter_if.slave (req, d0..d3, lock, gnt, sel,
//                out_valid, out_data, out_ready)
//   Optional feature macro: ARB_LOCK_EN
//     When ARB_LOCK_EN is defined, lock[sel] together with req[sel] at accept
//     time re-grants the same requester. When the macro is undefined, lock is
//     ignored.

// 4:1 word mux. The select values 0..3 pick a, b, d and e.
module yMux4to1 #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic [1:0]   c,
  output logic [W-1:0] z
);
  always_comb begin
    case (c)
      2'd0:    z = a;
      2'd1:    z = b;
      2'd2:    z = d;
      default: z = e;
    endcase
  end
endmodule

module ymux4_rr_arbiter #(parameter int W = 8) (
  input  logic                   clk,
  input  logic                   reset_n,
  ymux4_rr_arbiter_if.slave      bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2} state_t;

  state_t       state_q;
  logic [3:0]   gnt_q;
  logic [1:0]   sel_q;
  logic [1:0]   last_q;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;

  logic [W-1:0] z;
  logic [1:0]   rr_win;
  logic [1:0]   idx;
  logic         found;
  logic         lock_hold;
  logic [1:0]   win_d;
  logic         accept;

  yMux4to1 #(.W(W)) u_mux (
    .a (bus.d0),
    .b (bus.d1),
    .d (bus.d2),
    .e (bus.d3),
    .c (sel_q),
    .z (z)
  );

  // Scan last+1, last+2, ... with 2-bit wraparound. The case k=4 lands back on
  // last, so a lone requester is re-granted every round.
  always_comb begin
    rr_win = last_q;
    idx    = last_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        rr_win = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Lock only matters at an XFER accept, where sel still names the previous winner.
  assign lock_hold = bus.lock[sel_q] && bus.req[sel_q];
`else
  logic lock_unused;
  assign lock_unused = ^bus.lock;
  assign lock_hold   = 1'b0;
`endif

  assign accept = (state_q == XFER) && out_valid_q && bus.out_ready;
  assign win_d  = (accept && lock_hold) ? sel_q : rr_win;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            sel_q   <= win_d;
            gnt_q   <= 4'(1) << win_d;
            state_q <= ARB;
          end else begin
            gnt_q   <= 4'b0000;
          end
        end
        ARB: begin
          // The mux has settled on the registered sel during this cycle.
          out_data_q  <= z;
          out_valid_q <= 1'b1;
          gnt_q       <= 4'b0000;
          last_q      <= sel_q;
          state_q     <= XFER;
        end
        XFER: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            if (|bus.req) begin
              sel_q   <= win_d;
              gnt_q   <= 4'(1) << win_d;
              state_q <= ARB;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_ymux4_rr_arbiter.sv
module tb_ymux4_rr_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  ymux4_rr_arbiter_if #(.W(8)) bus ();

  ymux4_rr_arbiter #(.W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n       = 1'b0;
    bus.req       = 4'h0;
    bus.lock      = 4'h0;
    bus.out_ready = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    bus.req = 4'hF; bus.lock = 4'h0; bus.out_ready = 1'b1;
    bus.d0 = 8'h11; bus.d1 = 8'h22; bus.d2 = 8'h33; bus.d3 = 8'h44;
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt got %h exp 0", bus.gnt); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", bus.sel); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.out_data); end
  endtask

  task automatic test_single;
    bus.req = 4'b0100; bus.d2 = 8'hA5; bus.out_ready = 1'b1;
    reset_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", bus.gnt); end
    checks++; if (bus.sel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d exp 2", bus.sel); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", bus.out_data); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_off got %b exp 0000", bus.gnt); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] eg [5];
    logic [7:0] ed [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    do_reset();
    bus.d0 = 8'h11; bus.d1 = 8'h22; bus.d2 = 8'h33; bus.d3 = 8'h44;
    bus.req = 4'hF; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.gnt !== eg[i]) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, bus.gnt, eg[i]); end
      tick();
      checks++; if (bus.out_data !== ed[i] || bus.out_valid !== 1'b1)
        begin errors++; $display("FAIL rr_data[%0d] got %h/%b exp %h/1", i, bus.out_data, bus.out_valid, ed[i]); end
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_gnt_off[%0d] got %b exp 0000", i, bus.gnt); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    bus.d0 = 8'h5A; bus.d1 = 8'hC3;
    bus.req = 4'b0011; bus.out_ready = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt0 got %b exp 0001", bus.gnt); end
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.out_data !== 8'h5A || bus.out_valid !== 1'b1 || bus.sel !== 2'd0 || bus.gnt !== 4'b0000)
        begin errors++; $display("FAIL bp_hold[%0d] got d=%h v=%b s=%0d g=%b exp d=5a v=1 s=0 g=0000",
                                   i, bus.out_data, bus.out_valid, bus.sel, bus.gnt); end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0010 || bus.sel !== 2'd1 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_accept got g=%b s=%0d v=%b exp g=0010 s=1 v=0", bus.gnt, bus.sel, bus.out_valid); end
    tick();
    checks++; if (bus.out_data !== 8'hC3) begin errors++; $display("FAIL bp_next_data got %h exp c3", bus.out_data); end
  endtask

  task automatic test_reset_mid_xfer;
    do_reset();
    bus.req = 4'hF; bus.out_ready = 1'b0;
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", bus.out_valid); end
    reset_n = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.gnt !== 4'h0 || bus.sel !== 2'd0 || bus.out_data !== 8'h00)
      begin errors++; $display("FAIL mid_reset got v=%b g=%b s=%0d d=%h exp 0/0000/0/00",
                                 bus.out_valid, bus.gnt, bus.sel, bus.out_data); end
    reset_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_first_gnt got %b exp 0001", bus.gnt); end
  endtask

  task automatic test_lock;
    logic [3:0] eg [5];
`ifdef ARB_LOCK_EN
    eg = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    bus.req = 4'hF; bus.lock = 4'b0010; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.gnt !== eg[i]) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp %b", i, bus.gnt, eg[i]); end
      if (i == 3) bus.lock = 4'b0000;
      tick();
    end
    bus.lock = 4'b0000;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req = 4'h0; bus.lock = 4'h0; bus.out_ready = 1'b0;
    bus.d0 = 8'h00; bus.d1 = 8'h00; bus.d2 = 8'h00; bus.d3 = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_xfer();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
